// File: rtl/alu_issue_wb_pkg.sv
// Shared ALU op codes, default widths and small helpers for the issue/writeback slice.
package alu_issue_wb_pkg;

  localparam int unsigned PKG_DATAPATH_WIDTH = 64;
  localparam int unsigned PKG_REG_ADDR_WIDTH = 5;
  localparam int unsigned PKG_IMM_WIDTH      = 16;
  localparam int unsigned ALU_OP_WIDTH       = 4;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4
  } alu_op_e;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_MAX = 4'd4;

  // Op codes above ALU_OP_MAX produce a zero result and never write the register file.
  function automatic logic op_legal(input logic [ALU_OP_WIDTH-1:0] op);
    return (op <= ALU_OP_MAX);
  endfunction

endpackage

// File: rtl/alu_issue_wb_if.sv
// Op-issue channel from the decoder and result channel to the consumer.
interface alu_issue_wb_if
  import alu_issue_wb_pkg::*;
#(
  parameter int unsigned DATAPATH_WIDTH = PKG_DATAPATH_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH = PKG_REG_ADDR_WIDTH,
  parameter int unsigned IMM_WIDTH      = PKG_IMM_WIDTH
) ();

  logic                      in_valid;
  logic                      in_ready;
  logic [ALU_OP_WIDTH-1:0]   in_op;
  logic [REG_ADDR_WIDTH-1:0] in_rd;
  logic [REG_ADDR_WIDTH-1:0] in_rs1;
  logic [REG_ADDR_WIDTH-1:0] in_rs2;
  logic                      in_use_imm;
  logic [IMM_WIDTH-1:0]      in_imm;

  logic                      res_valid;
  logic                      res_ready;
  logic [DATAPATH_WIDTH-1:0] res_data;
  logic [REG_ADDR_WIDTH-1:0] res_rd;
  logic                      res_illegal;

  // Upstream decoder and downstream consumer side.
  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_use_imm, in_imm,
    input  in_ready,
    input  res_valid, res_data, res_rd, res_illegal,
    output res_ready
  );

  // Issue/writeback stage side.
  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_use_imm, in_imm,
    output in_ready,
    output res_valid, res_data, res_rd, res_illegal,
    input  res_ready
  );

endinterface

// File: rtl/alu_issue_wb_alu.sv
// Combinational ALU: add/sub/and/or/xor, wrapping arithmetic, zero for unknown ops.
module alu_issue_wb_alu
  import alu_issue_wb_pkg::*;
#(
  parameter int unsigned DATAPATH_WIDTH = PKG_DATAPATH_WIDTH
) (
  input  logic [ALU_OP_WIDTH-1:0]   i_op,
  input  logic [DATAPATH_WIDTH-1:0] i_a,
  input  logic [DATAPATH_WIDTH-1:0] i_b,
  output logic [DATAPATH_WIDTH-1:0] o_y_c
);

  // Operation select; illegal codes fall through to zero.
  always_comb begin
    o_y_c = '0;
    case (i_op)
      ALU_ADD: o_y_c = i_a + i_b;
      ALU_SUB: o_y_c = i_a - i_b;
      ALU_AND: o_y_c = i_a & i_b;
      ALU_OR:  o_y_c = i_a | i_b;
      ALU_XOR: o_y_c = i_a ^ i_b;
      default: o_y_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_issue_wb.sv
// Issue/writeback stage: ISSUE (regfile read + forward) -> EX (ALU) -> RES (registered result).
module alu_issue_wb
  import alu_issue_wb_pkg::*;
#(
  parameter int unsigned DATAPATH_WIDTH = PKG_DATAPATH_WIDTH,
  parameter int unsigned REG_ADDR_WIDTH = PKG_REG_ADDR_WIDTH,
  parameter int unsigned IMM_WIDTH      = PKG_IMM_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  alu_issue_wb_if.slave io_bus
);

  localparam int unsigned NUM_REGS = 2 ** REG_ADDR_WIDTH;
  localparam int unsigned EXT_W    = DATAPATH_WIDTH - IMM_WIDTH;

  logic [DATAPATH_WIDTH-1:0] r_regs [NUM_REGS];

  logic                      r_ex_valid;
  logic [ALU_OP_WIDTH-1:0]   r_ex_op;
  logic [REG_ADDR_WIDTH-1:0] r_ex_rd;
  logic [DATAPATH_WIDTH-1:0] r_ex_a;
  logic [DATAPATH_WIDTH-1:0] r_ex_b;

  logic                      r_res_valid;
  logic [DATAPATH_WIDTH-1:0] r_res_data;
  logic [REG_ADDR_WIDTH-1:0] r_res_rd;
  logic                      r_res_illegal;

  logic                      w_advance;
  logic                      w_in_ready;
  logic                      w_accept;
  logic                      w_ex_move;
  logic                      w_ex_legal;
  logic                      w_fwd_ok;
  logic [DATAPATH_WIDTH-1:0] w_alu_y;
  logic [DATAPATH_WIDTH-1:0] w_imm_ext;
  logic [DATAPATH_WIDTH-1:0] w_op_a;
  logic [DATAPATH_WIDTH-1:0] w_op_b;

  assign w_advance  = !r_res_valid || io_bus.res_ready;
  assign w_in_ready = !reset && (w_advance || !r_ex_valid);
  assign w_accept   = io_bus.in_valid && w_in_ready;
  assign w_ex_move  = r_ex_valid && w_advance;
  assign w_ex_legal = op_legal(r_ex_op);
  assign w_fwd_ok   = r_ex_valid && w_ex_legal;
  assign w_imm_ext  = {{EXT_W{io_bus.in_imm[IMM_WIDTH-1]}}, io_bus.in_imm};

  assign io_bus.in_ready    = w_in_ready;
  assign io_bus.res_valid   = r_res_valid;
  assign io_bus.res_data    = r_res_data;
  assign io_bus.res_rd      = r_res_rd;
  assign io_bus.res_illegal = r_res_illegal;

  alu_issue_wb_alu #(
    .DATAPATH_WIDTH (DATAPATH_WIDTH)
  ) u_alu (
    .i_op  (r_ex_op),
    .i_a   (r_ex_a),
    .i_b   (r_ex_b),
    .o_y_c (w_alu_y)
  );

  // Operand A: r0 is zero, otherwise forward a legal in-flight EX result or read the regfile.
  always_comb begin
    w_op_a = '0;
    if (io_bus.in_rs1 != '0) begin
      if (w_fwd_ok && (r_ex_rd == io_bus.in_rs1)) w_op_a = w_alu_y;
      else                                        w_op_a = r_regs[io_bus.in_rs1];
    end
  end

  // Operand B: immediate wins over rs2; otherwise same rules as operand A.
  always_comb begin
    w_op_b = '0;
    if (io_bus.in_use_imm) begin
      w_op_b = w_imm_ext;
    end else if (io_bus.in_rs2 != '0) begin
      if (w_fwd_ok && (r_ex_rd == io_bus.in_rs2)) w_op_b = w_alu_y;
      else                                        w_op_b = r_regs[io_bus.in_rs2];
    end
  end

  // EX stage registers: load on accept, drain when the result moves on.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_valid <= 1'b0;
      r_ex_op    <= '0;
      r_ex_rd    <= '0;
      r_ex_a     <= '0;
      r_ex_b     <= '0;
    end else if (w_accept) begin
      r_ex_valid <= 1'b1;
      r_ex_op    <= io_bus.in_op;
      r_ex_rd    <= io_bus.in_rd;
      r_ex_a     <= w_op_a;
      r_ex_b     <= w_op_b;
    end else if (w_ex_move) begin
      r_ex_valid <= 1'b0;
    end
  end

  // RES stage: capture ALU output on EX->RES, clear once the consumer takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_res_valid   <= 1'b0;
      r_res_data    <= '0;
      r_res_rd      <= '0;
      r_res_illegal <= 1'b0;
    end else if (w_ex_move) begin
      r_res_valid   <= 1'b1;
      r_res_data    <= w_alu_y;
      r_res_rd      <= r_ex_rd;
      r_res_illegal <= !w_ex_legal;
    end else if (r_res_valid && io_bus.res_ready) begin
      r_res_valid   <= 1'b0;
    end
  end

  // Register file write-back on the EX->RES edge; r0 and illegal ops never write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) r_regs[i] <= '0;
    end else if (w_ex_move && w_ex_legal && (r_ex_rd != '0)) begin
      r_regs[r_ex_rd] <= w_alu_y;
    end
  end

endmodule

// File: tb/tb_alu_issue_wb.sv
// Directed bench for alu_issue_wb: forwarding, immediates, stalls, illegal ops, r0, reset.
module tb_alu_issue_wb;
  import alu_issue_wb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  alu_issue_wb_if bus_if ();

  alu_issue_wb u_dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic [3:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic ui, input logic [15:0] imm);
    bus_if.in_valid   = v;
    bus_if.in_op      = op;
    bus_if.in_rd      = rd;
    bus_if.in_rs1     = rs1;
    bus_if.in_rs2     = rs2;
    bus_if.in_use_imm = ui;
    bus_if.in_imm     = imm;
    #1;
  endtask

  task automatic idle;
    set_op(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 1'b0, 16'd0);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus_if.res_ready = 1'b1;
    idle();
    tick();
    tick();
    checks++; if (bus_if.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus_if.in_ready); end
    checks++; if (bus_if.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", bus_if.res_valid); end
    checks++; if (bus_if.res_data !== 64'd0) begin errors++; $display("FAIL reset_res_data: got %h expected 0", bus_if.res_data); end
    checks++; if (bus_if.res_rd !== 5'd0) begin errors++; $display("FAIL reset_res_rd: got %0d expected 0", bus_if.res_rd); end
    checks++; if (bus_if.res_illegal !== 1'b0) begin errors++; $display("FAIL reset_res_illegal: got %b expected 0", bus_if.res_illegal); end
    reset = 1'b0;
    #1;
    checks++; if (bus_if.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", bus_if.in_ready); end
  endtask

  task automatic test_back_to_back;
    set_op(1'b1, ALU_ADD, 5'd1, 5'd0, 5'd0, 1'b1, 16'd5);
    tick();
    set_op(1'b1, ALU_ADD, 5'd2, 5'd1, 5'd0, 1'b1, 16'd7);
    checks++; if (bus_if.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b expected 1", bus_if.in_ready); end
    checks++; if (bus_if.res_valid !== 1'b0) begin errors++; $display("FAIL b2b_early_valid: got %b expected 0", bus_if.res_valid); end
    tick();
    idle();
    checks++; if (bus_if.res_valid !== 1'b1 || bus_if.res_data !== 64'd5 || bus_if.res_rd !== 5'd1)
      begin errors++; $display("FAIL b2b_res1: got v=%b d=%0d rd=%0d expected v=1 d=5 rd=1", bus_if.res_valid, bus_if.res_data, bus_if.res_rd); end
    tick();
    checks++; if (bus_if.res_valid !== 1'b1 || bus_if.res_data !== 64'd12 || bus_if.res_rd !== 5'd2)
      begin errors++; $display("FAIL b2b_res2: got v=%b d=%0d rd=%0d expected v=1 d=12 rd=2", bus_if.res_valid, bus_if.res_data, bus_if.res_rd); end
    tick();
    checks++; if (bus_if.res_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", bus_if.res_valid); end
  endtask

  task automatic test_imm_sign_ext;
    set_op(1'b1, ALU_ADD, 5'd3, 5'd0, 5'd0, 1'b1, 16'hFFFF);
    tick();
    idle();
    tick();
    checks++; if (bus_if.res_data !== 64'hFFFF_FFFF_FFFF_FFFF || bus_if.res_rd !== 5'd3)
      begin errors++; $display("FAIL imm_sign_ext: got d=%h rd=%0d expected d=ffffffffffffffff rd=3", bus_if.res_data, bus_if.res_rd); end
    tick();
  endtask

  task automatic test_logic_ops;
    // r1=5, r2=12 from the back-to-back test
    set_op(1'b1, ALU_SUB, 5'd10, 5'd1, 5'd2, 1'b0, 16'd0);
    tick();
    set_op(1'b1, ALU_AND, 5'd11, 5'd2, 5'd10, 1'b0, 16'd0);
    tick();
    set_op(1'b1, ALU_OR, 5'd12, 5'd1, 5'd2, 1'b0, 16'd0);
    checks++; if (bus_if.res_data !== 64'hFFFF_FFFF_FFFF_FFF9 || bus_if.res_rd !== 5'd10)
      begin errors++; $display("FAIL sub_wrap: got d=%h rd=%0d expected d=fffffffffffffff9 rd=10", bus_if.res_data, bus_if.res_rd); end
    tick();
    set_op(1'b1, ALU_XOR, 5'd13, 5'd12, 5'd1, 1'b0, 16'd0);
    checks++; if (bus_if.res_data !== 64'd8 || bus_if.res_rd !== 5'd11)
      begin errors++; $display("FAIL and_fwd_b: got d=%h rd=%0d expected d=8 rd=11", bus_if.res_data, bus_if.res_rd); end
    tick();
    set_op(1'b1, ALU_SUB, 5'd14, 5'd13, 5'd0, 1'b1, 16'hFFF9);
    checks++; if (bus_if.res_data !== 64'd13 || bus_if.res_rd !== 5'd12)
      begin errors++; $display("FAIL or: got d=%h rd=%0d expected d=13 rd=12", bus_if.res_data, bus_if.res_rd); end
    tick();
    idle();
    checks++; if (bus_if.res_data !== 64'd8 || bus_if.res_rd !== 5'd13)
      begin errors++; $display("FAIL xor_fwd_a: got d=%h rd=%0d expected d=8 rd=13", bus_if.res_data, bus_if.res_rd); end
    tick();
    checks++; if (bus_if.res_data !== 64'd15 || bus_if.res_rd !== 5'd14)
      begin errors++; $display("FAIL sub_imm_fwd: got d=%h rd=%0d expected d=15 rd=14", bus_if.res_data, bus_if.res_rd); end
    tick();
  endtask

  task automatic test_stall;
    bus_if.res_ready = 1'b0;
    set_op(1'b1, ALU_ADD, 5'd6, 5'd1, 5'd0, 1'b1, 16'd1);
    tick();
    set_op(1'b1, ALU_ADD, 5'd7, 5'd2, 5'd0, 1'b1, 16'd2);
    checks++; if (bus_if.in_ready !== 1'b1) begin errors++; $display("FAIL stall_second_accept: got %b expected 1", bus_if.in_ready); end
    tick();
    // a third op waits at the input and must not be taken while stalled
    set_op(1'b1, ALU_ADD, 5'd9, 5'd0, 5'd0, 1'b1, 16'd99);
    for (int c = 0; c < 3; c++) begin
      checks++; if (bus_if.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready c%0d: got %b expected 0", c, bus_if.in_ready); end
      checks++; if (bus_if.res_valid !== 1'b1 || bus_if.res_data !== 64'd6 || bus_if.res_rd !== 5'd6)
        begin errors++; $display("FAIL stall_hold c%0d: got v=%b d=%0d rd=%0d expected v=1 d=6 rd=6", c, bus_if.res_valid, bus_if.res_data, bus_if.res_rd); end
      if (c < 2) tick();
    end
    idle();
    bus_if.res_ready = 1'b1;
    #1;
    checks++; if (bus_if.in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b expected 1", bus_if.in_ready); end
    tick();
    checks++; if (bus_if.res_valid !== 1'b1 || bus_if.res_data !== 64'd14 || bus_if.res_rd !== 5'd7)
      begin errors++; $display("FAIL stall_second_res: got v=%b d=%0d rd=%0d expected v=1 d=14 rd=7", bus_if.res_valid, bus_if.res_data, bus_if.res_rd); end
    tick();
    checks++; if (bus_if.res_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b expected 0", bus_if.res_valid); end
  endtask

  task automatic test_illegal;
    set_op(1'b1, ALU_ADD, 5'd4, 5'd0, 5'd0, 1'b1, 16'd33);
    tick();
    set_op(1'b1, 4'd9, 5'd4, 5'd1, 5'd0, 1'b1, 16'd1);
    tick();
    set_op(1'b1, ALU_ADD, 5'd8, 5'd4, 5'd0, 1'b1, 16'd0);
    checks++; if (bus_if.res_data !== 64'd33 || bus_if.res_rd !== 5'd4 || bus_if.res_illegal !== 1'b0)
      begin errors++; $display("FAIL illegal_pre: got d=%0d rd=%0d ill=%b expected d=33 rd=4 ill=0", bus_if.res_data, bus_if.res_rd, bus_if.res_illegal); end
    tick();
    idle();
    checks++; if (bus_if.res_data !== 64'd0 || bus_if.res_rd !== 5'd4 || bus_if.res_illegal !== 1'b1)
      begin errors++; $display("FAIL illegal_res: got d=%0d rd=%0d ill=%b expected d=0 rd=4 ill=1", bus_if.res_data, bus_if.res_rd, bus_if.res_illegal); end
    tick();
    checks++; if (bus_if.res_data !== 64'd33 || bus_if.res_rd !== 5'd8 || bus_if.res_illegal !== 1'b0)
      begin errors++; $display("FAIL illegal_no_write: got d=%0d rd=%0d ill=%b expected d=33 rd=8 ill=0", bus_if.res_data, bus_if.res_rd, bus_if.res_illegal); end
    tick();
  endtask

  task automatic test_r0_write;
    set_op(1'b1, ALU_ADD, 5'd0, 5'd0, 5'd0, 1'b1, 16'd3);
    tick();
    set_op(1'b1, ALU_ADD, 5'd5, 5'd0, 5'd0, 1'b0, 16'd0);
    tick();
    idle();
    checks++; if (bus_if.res_data !== 64'd3 || bus_if.res_rd !== 5'd0)
      begin errors++; $display("FAIL r0_write_res: got d=%0d rd=%0d expected d=3 rd=0", bus_if.res_data, bus_if.res_rd); end
    tick();
    checks++; if (bus_if.res_data !== 64'd0 || bus_if.res_rd !== 5'd5)
      begin errors++; $display("FAIL r0_reads_zero: got d=%0d rd=%0d expected d=0 rd=5", bus_if.res_data, bus_if.res_rd); end
    tick();
  endtask

  task automatic test_reset_mid;
    bus_if.res_ready = 1'b0;
    set_op(1'b1, ALU_ADD, 5'd15, 5'd0, 5'd0, 1'b1, 16'd77);
    tick();
    set_op(1'b1, ALU_ADD, 5'd16, 5'd0, 5'd0, 1'b1, 16'd88);
    tick();
    idle();
    checks++; if (bus_if.res_valid !== 1'b1 || bus_if.res_data !== 64'd77)
      begin errors++; $display("FAIL mid_fill: got v=%b d=%0d expected v=1 d=77", bus_if.res_valid, bus_if.res_data); end
    reset = 1'b1;
    tick();
    checks++; if (bus_if.res_valid !== 1'b0 || bus_if.res_data !== 64'd0 || bus_if.in_ready !== 1'b0)
      begin errors++; $display("FAIL mid_reset: got v=%b d=%0d rdy=%b expected v=0 d=0 rdy=0", bus_if.res_valid, bus_if.res_data, bus_if.in_ready); end
    reset = 1'b0;
    bus_if.res_ready = 1'b1;
    tick();
    checks++; if (bus_if.res_valid !== 1'b0) begin errors++; $display("FAIL mid_ex_cleared: got %b expected 0", bus_if.res_valid); end
    set_op(1'b1, ALU_ADD, 5'd17, 5'd16, 5'd15, 1'b0, 16'd0);
    tick();
    idle();
    tick();
    checks++; if (bus_if.res_data !== 64'd0 || bus_if.res_rd !== 5'd17)
      begin errors++; $display("FAIL mid_no_writeback: got d=%0d rd=%0d expected d=0 rd=17", bus_if.res_data, bus_if.res_rd); end
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_imm_sign_ext();
    test_logic_ops();
    test_stall();
    test_illegal();
    test_r0_write();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
